// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// datapath enable/select decode, a sticky HALT state and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_write,
  output logic             ir_write,
  output logic             write,
  output logic             mem_write,
  output logic [5:0]       alu_funct,
  output logic             rd_mux_s,
  output logic             op2_mux_s,
  output logic             branch_mux_s,
  output logic             j_mux_s,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_BAD    = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OPC_RTYPE = 3'd0,
    OPC_ADDI  = 3'd1,
    OPC_BEQ   = 3'd2,
    OPC_J     = 3'd3,
    OPC_LW    = 3'd4,
    OPC_SW    = 3'd5,
    OPC_HALT  = 3'd6,
    OPC_NOP   = 3'd7
  } opc_t;

  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;

  // Unrecognised opcodes collapse to NOP so they retire in two cycles.
  function automatic opc_t decode_op(input logic [5:0] op);
    opc_t res;
    case (op)
      6'b000000: res = OPC_RTYPE;
      6'b001000: res = OPC_ADDI;
      6'b000100: res = OPC_BEQ;
      6'b000010: res = OPC_J;
      6'b100011: res = OPC_LW;
      6'b101011: res = OPC_SW;
      6'b111111: res = OPC_HALT;
      default:   res = OPC_NOP;
    endcase
    return res;
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  state_t           boundary_s;
  opc_t             opc_s;
  logic             retire_s;
  logic             halted_r;
  logic [CNT_W-1:0] icount_r;

  logic       pc_write_s;
  logic       ir_write_s;
  logic       write_s;
  logic       mem_write_s;
  logic [5:0] alu_funct_s;
  logic       rd_mux_s_s;
  logic       op2_mux_s_s;
  logic       branch_mux_s_s;
  logic       j_mux_s_s;

  // State, halt flag and retire counter; reset overrides every transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      halted_r <= 1'b0;
      icount_r <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_next_s;
      halted_r <= (state_next_s == ST_HALT);
      if (retire_s) begin
        icount_r <= icount_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        icount_r <= icount_r;
      end
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    opc_s          = decode_op(opcode);
    boundary_s     = load ? ST_FETCH : ST_IDLE;
    state_next_s   = state_r;
    retire_s       = 1'b0;
    pc_write_s     = 1'b0;
    ir_write_s     = 1'b0;
    write_s        = 1'b0;
    mem_write_s    = 1'b0;
    alu_funct_s    = ALU_ADD;
    rd_mux_s_s     = 1'b0;
    op2_mux_s_s    = 1'b0;
    branch_mux_s_s = 1'b0;
    j_mux_s_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        state_next_s = load ? ST_FETCH : ST_IDLE;
      end
      ST_FETCH: begin
        ir_write_s   = 1'b1;
        pc_write_s   = 1'b1;
        state_next_s = ST_DECODE;
      end
      ST_DECODE: begin
        case (opc_s)
          OPC_J: begin
            pc_write_s   = 1'b1;
            j_mux_s_s    = 1'b1;
            retire_s     = 1'b1;
            state_next_s = boundary_s;
          end
          OPC_HALT: begin
            state_next_s = ST_HALT;
          end
          OPC_NOP: begin
            retire_s     = 1'b1;
            state_next_s = boundary_s;
          end
          default: begin
            state_next_s = ST_EXEC;
          end
        endcase
      end
      ST_EXEC: begin
        case (opc_s)
          OPC_RTYPE: begin
            alu_funct_s  = funct;
            state_next_s = ST_WB;
          end
          OPC_ADDI: begin
            op2_mux_s_s  = 1'b1;
            state_next_s = ST_WB;
          end
          OPC_LW, OPC_SW: begin
            op2_mux_s_s  = 1'b1;
            state_next_s = ST_MEM;
          end
          OPC_BEQ: begin
            alu_funct_s    = ALU_SUB;
            branch_mux_s_s = zero;
            pc_write_s     = zero;
            retire_s       = 1'b1;
            state_next_s   = boundary_s;
          end
          // Opcode changed under us: abandon without counting.
          default: begin
            state_next_s = boundary_s;
          end
        endcase
      end
      ST_MEM: begin
        case (opc_s)
          OPC_SW: begin
            mem_write_s  = 1'b1;
            retire_s     = 1'b1;
            state_next_s = boundary_s;
          end
          OPC_LW: begin
            state_next_s = ST_WB;
          end
          default: begin
            state_next_s = boundary_s;
          end
        endcase
      end
      ST_WB: begin
        write_s      = 1'b1;
        rd_mux_s_s   = (opc_s == OPC_RTYPE);
        retire_s     = 1'b1;
        state_next_s = boundary_s;
      end
      ST_HALT: begin
        state_next_s = ST_HALT;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  assign pc_write     = pc_write_s;
  assign ir_write     = ir_write_s;
  assign write        = write_s;
  assign mem_write    = mem_write_s;
  assign alu_funct    = alu_funct_s;
  assign rd_mux_s     = rd_mux_s_s;
  assign op2_mux_s    = op2_mux_s_s;
  assign branch_mux_s = branch_mux_s_s;
  assign j_mux_s      = j_mux_s_s;
  assign state        = state_r;
  assign halted       = halted_r;
  assign icount       = icount_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/control vectors against
// hand-computed tables, halt/reset behaviour and counter wrap at CNT_W=4.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_NOP  = 6'b000001;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  // ctrl bits: pc_write, ir_write, write, mem_write, rd_mux_s, op2_mux_s, branch_mux_s, j_mux_s
  localparam logic [7:0] C_NONE  = 8'h00;
  localparam logic [7:0] C_FETCH = 8'hC0;
  localparam logic [7:0] C_JMP   = 8'h81;
  localparam logic [7:0] C_IMM   = 8'h04;
  localparam logic [7:0] C_BR    = 8'h82;
  localparam logic [7:0] C_MEMW  = 8'h10;
  localparam logic [7:0] C_WBRD  = 8'h28;
  localparam logic [7:0] C_WB    = 8'h20;

  localparam logic [5:0] A_ADD = 6'b100000;
  localparam logic [5:0] A_SUB = 6'b100010;

  logic        clock = 1'b0;
  logic        reset, load, zero;
  logic [5:0]  opcode, funct;
  logic        pc_write, ir_write, write, mem_write, rd_mux_s, op2_mux_s, branch_mux_s, j_mux_s, halted;
  logic [5:0]  alu_funct;
  logic [2:0]  state;
  logic [15:0] icount;

  logic        load4;
  logic [5:0]  opcode4;
  logic        pc_write4, ir_write4, write4, mem_write4, rd_mux4, op2_mux4, br_mux4, j_mux4, halted4;
  logic [5:0]  alu_funct4;
  logic [2:0]  state4;
  logic [3:0]  icount4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  multicycle_ctrl #(.CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .load(load), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .write(write), .mem_write(mem_write),
    .alu_funct(alu_funct), .rd_mux_s(rd_mux_s), .op2_mux_s(op2_mux_s),
    .branch_mux_s(branch_mux_s), .j_mux_s(j_mux_s), .state(state), .halted(halted),
    .icount(icount)
  );

  multicycle_ctrl #(.CNT_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .load(load4), .opcode(opcode4), .funct(6'b000000), .zero(1'b0),
    .pc_write(pc_write4), .ir_write(ir_write4), .write(write4), .mem_write(mem_write4),
    .alu_funct(alu_funct4), .rd_mux_s(rd_mux4), .op2_mux_s(op2_mux4),
    .branch_mux_s(br_mux4), .j_mux_s(j_mux4), .state(state4), .halted(halted4),
    .icount(icount4)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge: drive inputs, sample mid-cycle, advance one edge.
  task automatic tick(input string tag, input logic ld, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic [2:0] es, input logic [7:0] ec, input logic [5:0] ea);
    load = ld; opcode = op; funct = fn; zero = z;
    #4;
    check(tag, {15'd0, state, pc_write, ir_write, write, mem_write, rd_mux_s, op2_mux_s,
                branch_mux_s, j_mux_s, alu_funct}, {15'd0, es, ec, ea});
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; opcode = OP_NOP; funct = 6'd0; zero = 1'b0;
    load4 = 1'b0; opcode4 = OP_NOP;
    @(posedge clock); #1;
    @(posedge clock); #1;
    tick("rst_vec", 1'b1, OP_R, A_SUB, 1'b0, S_IDLE, C_NONE, A_ADD);
    check("rst_icount", {16'd0, icount}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    reset = 1'b0;

    // RTYPE subtract: 1,2,3,5 then back to FETCH
    tick("r_idle",  1'b1, OP_R, A_SUB, 1'b0, S_IDLE,  C_NONE,  A_ADD);
    tick("r_fetch", 1'b1, OP_R, A_SUB, 1'b0, S_FETCH, C_FETCH, A_ADD);
    tick("r_dec",   1'b1, OP_R, A_SUB, 1'b0, S_DEC,   C_NONE,  A_ADD);
    tick("r_exec",  1'b1, OP_R, A_SUB, 1'b0, S_EXEC,  C_NONE,  A_SUB);
    tick("r_wb",    1'b1, OP_R, A_SUB, 1'b0, S_WB,    C_WBRD,  A_ADD);
    check("r_icount", {16'd0, icount}, 32'd1);

    tick("lw_fetch", 1'b1, OP_LW, 6'd0, 1'b0, S_FETCH, C_FETCH, A_ADD);
    tick("lw_dec",   1'b1, OP_LW, 6'd0, 1'b0, S_DEC,   C_NONE,  A_ADD);
    tick("lw_exec",  1'b1, OP_LW, 6'd0, 1'b0, S_EXEC,  C_IMM,   A_ADD);
    tick("lw_mem",   1'b1, OP_LW, 6'd0, 1'b0, S_MEM,   C_NONE,  A_ADD);
    tick("lw_wb",    1'b1, OP_LW, 6'd0, 1'b0, S_WB,    C_WB,    A_ADD);
    check("lw_icount", {16'd0, icount}, 32'd2);

    tick("sw_fetch", 1'b1, OP_SW, 6'd0, 1'b0, S_FETCH, C_FETCH, A_ADD);
    tick("sw_dec",   1'b1, OP_SW, 6'd0, 1'b0, S_DEC,   C_NONE,  A_ADD);
    tick("sw_exec",  1'b1, OP_SW, 6'd0, 1'b0, S_EXEC,  C_IMM,   A_ADD);
    tick("sw_mem",   1'b1, OP_SW, 6'd0, 1'b0, S_MEM,   C_MEMW,  A_ADD);
    check("sw_icount", {16'd0, icount}, 32'd3);

    tick("beq1_fetch", 1'b1, OP_BEQ, 6'd0, 1'b1, S_FETCH, C_FETCH, A_ADD);
    tick("beq1_dec",   1'b1, OP_BEQ, 6'd0, 1'b1, S_DEC,   C_NONE,  A_ADD);
    tick("beq1_exec",  1'b1, OP_BEQ, 6'd0, 1'b1, S_EXEC,  C_BR,    A_SUB);
    tick("beq0_fetch", 1'b1, OP_BEQ, 6'd0, 1'b0, S_FETCH, C_FETCH, A_ADD);
    tick("beq0_dec",   1'b1, OP_BEQ, 6'd0, 1'b0, S_DEC,   C_NONE,  A_ADD);
    tick("beq0_exec",  1'b1, OP_BEQ, 6'd0, 1'b0, S_EXEC,  C_NONE,  A_SUB);
    check("beq_icount", {16'd0, icount}, 32'd5);

    // ADDI with load dropped in EXEC still writes back, then parks in IDLE
    tick("addi_fetch", 1'b1, OP_ADDI, 6'd0, 1'b0, S_FETCH, C_FETCH, A_ADD);
    tick("addi_dec",   1'b1, OP_ADDI, 6'd0, 1'b0, S_DEC,   C_NONE,  A_ADD);
    tick("addi_exec",  1'b0, OP_ADDI, 6'd0, 1'b0, S_EXEC,  C_IMM,   A_ADD);
    tick("addi_wb",    1'b0, OP_ADDI, 6'd0, 1'b0, S_WB,    C_WB,    A_ADD);
    tick("idle_hold",  1'b0, OP_ADDI, 6'd0, 1'b0, S_IDLE,  C_NONE,  A_ADD);
    check("addi_icount", {16'd0, icount}, 32'd6);
    tick("idle_go",    1'b1, OP_NOP, 6'd0, 1'b0, S_IDLE,  C_NONE,  A_ADD);

    tick("nop_fetch", 1'b1, OP_NOP, 6'd0, 1'b0, S_FETCH, C_FETCH, A_ADD);
    tick("nop_dec",   1'b0, OP_NOP, 6'd0, 1'b0, S_DEC,   C_NONE,  A_ADD);
    check("nop_icount", {16'd0, icount}, 32'd7);
    tick("nop_idle",  1'b1, OP_J,   6'd0, 1'b0, S_IDLE,  C_NONE,  A_ADD);

    tick("j_fetch", 1'b1, OP_J, 6'd0, 1'b0, S_FETCH, C_FETCH, A_ADD);
    tick("j_dec",   1'b1, OP_J, 6'd0, 1'b0, S_DEC,   C_JMP,   A_ADD);
    check("j_icount", {16'd0, icount}, 32'd8);

    tick("h_fetch", 1'b1, OP_HALT, 6'd0, 1'b0, S_FETCH, C_FETCH, A_ADD);
    tick("h_dec",   1'b1, OP_HALT, 6'd0, 1'b0, S_DEC,   C_NONE,  A_ADD);
    check("h_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick("halt_hold", i[0], OP_R, 6'd0, 1'b0, S_HALT, C_NONE, A_ADD);
    end
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_icount", {16'd0, icount}, 32'd8);

    reset = 1'b1;
    tick("halt_rst", 1'b1, OP_HALT, 6'd0, 1'b0, S_HALT, C_NONE, A_ADD);
    reset = 1'b0;
    check("rst2_state",  {29'd0, state}, 32'd0);
    check("rst2_icount", {16'd0, icount}, 32'd0);
    check("rst2_halted", {31'd0, halted}, 32'd0);

    // Reset mid-instruction aborts without retiring
    tick("m_idle",  1'b1, OP_R, A_SUB, 1'b0, S_IDLE,  C_NONE,  A_ADD);
    tick("m_fetch", 1'b1, OP_R, A_SUB, 1'b0, S_FETCH, C_FETCH, A_ADD);
    tick("m_dec",   1'b1, OP_R, A_SUB, 1'b0, S_DEC,   C_NONE,  A_ADD);
    reset = 1'b1;
    tick("m_exec",  1'b1, OP_R, A_SUB, 1'b0, S_EXEC,  C_NONE,  A_SUB);
    reset = 1'b0;
    check("m_state",  {29'd0, state}, 32'd0);
    check("m_icount", {16'd0, icount}, 32'd0);

    // CNT_W=4 counter wrap: 15 NOPs reach all-ones, the 16th wraps to 0
    load = 1'b0;
    load4 = 1'b1; opcode4 = OP_NOP;
    @(posedge clock); #1;
    repeat (30) begin
      @(posedge clock); #1;
    end
    check("w_state",  {29'd0, state4}, {29'd0, S_FETCH});
    check("w_full",   {28'd0, icount4}, 32'd15);
    repeat (2) begin
      @(posedge clock); #1;
    end
    check("w_wrap",   {28'd0, icount4}, 32'd0);
    check("w_main_idle", {29'd0, state}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of retired-instruction counter.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising clock edge.
REQ-004 load  input  1  run enable; 1 = start/continue execution, 0 = stop at next instruction boundary.
REQ-005 opcode  input  6  opcode field of instruction register (valid from DECODE onward).
REQ-006 funct  input  6  funct field of instruction register.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 pc_write  output  1  PC load enable.
REQ-009 ir_write  output  1  instruction register load enable.
REQ-010 write  output  1  register-file write enable.
REQ-011 mem_write  output  1  data-memory write enable.
REQ-012 alu_funct  output  6  ALU operation code.
REQ-013 rd_mux_s  output  1  destination select: 1 = rd, 0 = rt.
REQ-014 op2_mux_s  output  1  ALU operand 2 select: 1 = sign-extended immediate, 0 = rt.
REQ-015 branch_mux_s  output  1  PC source = branch target.
REQ-016 j_mux_s  output  1  PC source = jump target.
REQ-017 state  output  3  current state encoding.
REQ-018 halted  output  1  1 while in HALT.
REQ-019 icount  output  CNT_W  retired-instruction count.

Function
REQ-020 States/encoding SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; code 7 SHALL go to IDLE next cycle.
REQ-021 Decoded opcodes: RTYPE 000000, ADDI 001000, BEQ 000100, J 000010, LW 100011, SW 101011, HALT 111111; any other opcode SHALL be a NOP.
REQ-022 All enable/select outputs SHALL be 0 and alu_funct 100000 unless a state below asserts them (combinational from state, opcode, funct, zero).
REQ-023 IDLE: load=1 -> FETCH; else stay.
REQ-024 FETCH: ir_write=1, pc_write=1 (PC+4); -> DECODE.
REQ-025 DECODE: J -> pc_write=1, j_mux_s=1, retire, next boundary; HALT -> HALT; NOP -> retire, next boundary; else -> EXEC.
REQ-026 EXEC: RTYPE alu_funct=funct, -> WB; ADDI/LW/SW op2_mux_s=1, alu_funct=100000, ADDI -> WB, LW/SW -> MEM; BEQ alu_funct=100010, branch_mux_s=zero, pc_write=zero, retire, next boundary.
REQ-027 MEM: SW mem_write=1, retire, next boundary; LW -> WB.
REQ-028 WB: write=1; rd_mux_s=1 for RTYPE, 0 otherwise; retire, next boundary.
REQ-029 "Next boundary" SHALL be FETCH if load=1 in that cycle, IDLE if load=0; load changes mid-instruction SHALL NOT abort the instruction.
REQ-030 Retire SHALL increment icount by 1 in that cycle, modulo 2^CNT_W (all-ones wraps to 0); HALT SHALL NOT count.
REQ-031 HALT: halted=1, all enables 0, held regardless of load until reset.
REQ-032 Cycle counts: J/NOP 2, BEQ 3, SW 4, RTYPE/ADDI 4, LW 5.

Reset
REQ-033 reset=1 at a rising edge SHALL force state=IDLE, icount=0, halted=0, taking priority over every transition, including mid-instruction and in HALT.
REQ-034 During and after reset all enables SHALL be 0 until FETCH.

Verification
REQ-035 Reset, load=1, RTYPE funct=100010 -> states 1,2,3,5,1; alu_funct=100010 in EXEC; write=1, rd_mux_s=1 in WB; icount=1.
REQ-036 LW then SW, load=1 -> LW 5 cycles ending with write=1, rd_mux_s=0; SW mem_write=1 in MEM only; icount=2.
REQ-037 BEQ zero=1 then zero=0 -> pc_write=branch_mux_s=1 only in first EXEC; both instructions 3 cycles.
REQ-038 J, then opcode 111111 -> j_mux_s=pc_write=1 in DECODE; then HALT, halted=1, icount unchanged with load toggling 10 cycles; reset -> IDLE, icount=0.
REQ-039 load dropped during ADDI EXEC -> WB completes with write=1, then IDLE; icount preset to all-ones with CNT_W=4 wraps to 0 on retire.
